// File: rtl/multichannel_ratio_divider.sv
// Channel-tagged signed/unsigned fixed-point divider: (error<<FRAC_BITS)/reference, restoring radix-2.
// Latency: DATA_SIZE+FRAC_BITS+1 edges from accept (1 edge for a zero divisor); one operation in flight.
// Backpressure: result held in DONE until i_ready; o_ready only in IDLE.
module multichannel_ratio_divider #(
  parameter int DATA_SIZE    = 14,
  parameter int FRAC_BITS    = 8,
  parameter int CHANNEL_SIZE = 3
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic [DATA_SIZE-1:0]                i_error,
  input  logic [DATA_SIZE-1:0]                i_reference,
  input  logic                                i_signed,
  input  logic [CHANNEL_SIZE-1:0]             i_channel,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [DATA_SIZE+FRAC_BITS-1:0]      o_quotient,
  output logic [DATA_SIZE-1:0]                o_remainder,
  output logic [CHANNEL_SIZE-1:0]             o_channel,
  output logic                                o_div_by_zero,
  output logic                                o_overflow
);

  localparam int RESULT_SIZE = DATA_SIZE + FRAC_BITS;
  localparam int CNT_W       = $clog2(RESULT_SIZE);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                   state;
  logic [RESULT_SIZE-1:0]   dvd;
  logic [DATA_SIZE-1:0]     dsr;
  logic [DATA_SIZE-1:0]     rem;
  logic [CNT_W-1:0]         cnt;
  logic [CHANNEL_SIZE-1:0]  ch_r;
  logic                     neg_q;
  logic                     neg_r;
  logic                     ovf_pend;

  logic [DATA_SIZE-1:0]     abs_err;
  logic [DATA_SIZE-1:0]     abs_ref;
  logic                     err_neg;
  logic                     ref_neg;
  logic                     is_ovf;
  logic [RESULT_SIZE-1:0]   dz_quot;
  logic [DATA_SIZE:0]       rem_shift;
  logic [DATA_SIZE:0]       rem_sub;
  logic                     q_bit;

  always_comb begin
    err_neg = i_signed & i_error[DATA_SIZE-1];
    ref_neg = i_signed & i_reference[DATA_SIZE-1];
    // Negating the most negative operand yields its correct unsigned magnitude.
    abs_err = err_neg ? (~i_error + 1'b1) : i_error;
    abs_ref = ref_neg ? (~i_reference + 1'b1) : i_reference;
    is_ovf  = i_signed && (i_error == {1'b1, {(DATA_SIZE-1){1'b0}}}) && (&i_reference);
    if (!i_signed)
      dz_quot = {RESULT_SIZE{1'b1}};
    else if (i_error[DATA_SIZE-1])
      dz_quot = {1'b1, {(RESULT_SIZE-1){1'b0}}};
    else
      dz_quot = {1'b0, {(RESULT_SIZE-1){1'b1}}};
    rem_shift = {rem, dvd[RESULT_SIZE-1]};
    rem_sub   = rem_shift - {1'b0, dsr};
    q_bit     = ~rem_sub[DATA_SIZE];
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      dvd           <= '0;
      dsr           <= '0;
      rem           <= '0;
      cnt           <= '0;
      ch_r          <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      ovf_pend      <= 1'b0;
      o_ready       <= 1'b0;
      o_valid       <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_channel     <= '0;
      o_div_by_zero <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (o_ready && i_valid) begin
            o_ready       <= 1'b0;
            o_div_by_zero <= 1'b0;
            o_overflow    <= 1'b0;
            ch_r          <= i_channel;
            if (i_reference == '0) begin
              o_valid       <= 1'b1;
              o_div_by_zero <= 1'b1;
              o_quotient    <= dz_quot;
              o_remainder   <= i_error;
              o_channel     <= i_channel;
              state         <= DONE;
            end else begin
              dvd      <= {abs_err, {FRAC_BITS{1'b0}}};
              dsr      <= abs_ref;
              rem      <= '0;
              cnt      <= '0;
              neg_q    <= err_neg ^ ref_neg;
              neg_r    <= err_neg;
              ovf_pend <= is_ovf;
              state    <= CALC;
            end
          end else begin
            o_ready <= 1'b1;
          end
        end
        CALC: begin
          // dvd shifts the dividend out MSB-first and the quotient in LSB-first.
          dvd <= {dvd[RESULT_SIZE-2:0], q_bit};
          rem <= q_bit ? rem_sub[DATA_SIZE-1:0] : rem_shift[DATA_SIZE-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(RESULT_SIZE-1))
            state <= FIX;
        end
        FIX: begin
          if (ovf_pend) begin
            o_quotient  <= {1'b0, {(RESULT_SIZE-1){1'b1}}};
            o_remainder <= '0;
            o_overflow  <= 1'b1;
          end else begin
            o_quotient  <= neg_q ? (~dvd + 1'b1) : dvd;
            o_remainder <= neg_r ? (~rem + 1'b1) : rem;
          end
          o_channel <= ch_r;
          o_valid   <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multichannel_ratio_divider.sv
// Scoreboard bench for multichannel_ratio_divider: expected results are queued at
// accept time from an integer reference model and compared when o_valid appears.
module tb_multichannel_ratio_divider;

  localparam int DW = 14;
  localparam int FW = 8;
  localparam int CW = 3;
  localparam int RW = DW + FW;
  localparam int SCALE = 1 << FW;
  localparam int LAT = RW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_error = '0;
  logic [DW-1:0] i_reference = '0;
  logic          i_signed = 1'b0;
  logic [CW-1:0] i_channel = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [RW-1:0] o_quotient;
  logic [DW-1:0] o_remainder;
  logic [CW-1:0] o_channel;
  logic          o_div_by_zero;
  logic          o_overflow;

  typedef struct packed {
    logic [RW-1:0] q;
    logic [DW-1:0] r;
    logic [CW-1:0] ch;
    logic          dz;
    logic          ov;
  } res_t;

  res_t obs;
  res_t exp_r;
  res_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  assign obs = {o_quotient, o_remainder, o_channel, o_div_by_zero, o_overflow};

  always #5 clk = ~clk;

  multichannel_ratio_divider #(.DATA_SIZE(DW), .FRAC_BITS(FW), .CHANNEL_SIZE(CW)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_error(i_error), .i_reference(i_reference), .i_signed(i_signed),
    .i_channel(i_channel), .o_valid(o_valid), .i_ready(i_ready),
    .o_quotient(o_quotient), .o_remainder(o_remainder), .o_channel(o_channel),
    .o_div_by_zero(o_div_by_zero), .o_overflow(o_overflow)
  );

  function automatic res_t model(logic [DW-1:0] e, logic [DW-1:0] r, logic s, logic [CW-1:0] ch);
    res_t m;
    int ei, ri, q, rm;
    m = '0;
    m.ch = ch;
    if (s) begin
      ei = $signed(e);
      ri = $signed(r);
    end else begin
      ei = int'(e);
      ri = int'(r);
    end
    if (ri == 0) begin
      m.dz = 1'b1;
      m.r  = e;
      if (!s) m.q = {RW{1'b1}};
      else if (ei >= 0) m.q = {1'b0, {(RW-1){1'b1}}};
      else m.q = {1'b1, {(RW-1){1'b0}}};
    end else if (s && ei == -(1 << (DW-1)) && ri == -1) begin
      m.ov = 1'b1;
      m.q  = {1'b0, {(RW-1){1'b1}}};
      m.r  = '0;
    end else begin
      q  = (ei * SCALE) / ri;
      rm = (ei * SCALE) % ri;
      m.q = q[RW-1:0];
      m.r = rm[DW-1:0];
    end
    return m;
  endfunction

  task automatic send_op(input logic [DW-1:0] e, input logic [DW-1:0] r,
                         input logic s, input logic [CW-1:0] ch);
    int w = 0;
    @(negedge clk);
    while (o_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (o_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_ready_timeout o_ready=%b required 1", o_ready);
    end
    i_valid = 1'b1;
    i_error = e;
    i_reference = r;
    i_signed = s;
    i_channel = ch;
    exp_q.push_back(model(e, r, s, ch));
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    // Scramble operands after accept; the DUT must have latched them.
    i_error = DW'($urandom);
    i_reference = DW'($urandom);
    i_signed = 1'($urandom);
    i_channel = CW'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (o_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_result();
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({obs, o_valid, o_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %h required 0", {obs, o_valid, o_ready});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready o_ready=%b o_valid=%b required 1/0", o_ready, o_valid);
    end
  endtask

  task automatic test_unsigned();
    int lat;
    send_op(14'd100, 14'd7, 1'b0, 3'd5);
    wait_valid(lat);
    exp_r = exp_q.pop_front();
    checks++;
    if (lat != LAT) begin failures++; $display("FAIL unsigned_latency got %0d required %0d", lat, LAT); end
    checks++;
    if (obs !== exp_r) begin failures++; $display("FAIL unsigned_result got %h required %h", obs, exp_r); end
    checks++;
    if (o_quotient !== 22'd3657 || o_remainder !== 14'd1 || o_channel !== 3'd5) begin
      failures++;
      $display("FAIL unsigned_const q=%0d r=%0d ch=%0d required 3657/1/5", o_quotient, o_remainder, o_channel);
    end
    take_result();
  endtask

  task automatic test_signed();
    int lat;
    send_op(14'h3F9C, 14'd7, 1'b1, 3'd2);
    wait_valid(lat);
    exp_r = exp_q.pop_front();
    checks++;
    if (obs !== exp_r) begin failures++; $display("FAIL signed_neg_pos got %h required %h", obs, exp_r); end
    checks++;
    if (o_quotient !== 22'h3FF1B7 || o_remainder !== 14'h3FFF) begin
      failures++;
      $display("FAIL signed_neg_pos_const q=%h r=%h required 3ff1b7/3fff", o_quotient, o_remainder);
    end
    take_result();
    send_op(14'h3F9C, 14'h3FF9, 1'b1, 3'd3);
    wait_valid(lat);
    exp_r = exp_q.pop_front();
    checks++;
    if (obs !== exp_r || o_quotient !== 22'd3657 || o_remainder !== 14'h3FFF) begin
      failures++;
      $display("FAIL signed_neg_neg got %h required %h", obs, exp_r);
    end
    take_result();
  endtask

  task automatic test_div_zero();
    int lat;
    send_op(14'd5, 14'd0, 1'b0, 3'd1);
    wait_valid(lat);
    exp_r = exp_q.pop_front();
    checks++;
    if (lat != 0) begin failures++; $display("FAIL divzero_latency got %0d required 0", lat); end
    checks++;
    if (obs !== exp_r || o_quotient !== 22'h3FFFFF || o_div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL divzero_unsigned got %h required %h", obs, exp_r);
    end
    take_result();
    send_op(14'h3FFB, 14'd0, 1'b1, 3'd3);
    wait_valid(lat);
    exp_r = exp_q.pop_front();
    checks++;
    if (obs !== exp_r || o_quotient !== 22'h200000 || o_remainder !== 14'h3FFB) begin
      failures++;
      $display("FAIL divzero_signed got %h required %h", obs, exp_r);
    end
    take_result();
  endtask

  task automatic test_overflow();
    int lat;
    send_op(14'h2000, 14'h3FFF, 1'b1, 3'd4);
    wait_valid(lat);
    exp_r = exp_q.pop_front();
    checks++;
    if (obs !== exp_r || o_quotient !== 22'h1FFFFF || o_remainder !== 14'd0 || o_overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow got %h required %h", obs, exp_r);
    end
    take_result();
    // Flags from the previous result must clear on the next accept.
    send_op(14'h2000, 14'd1, 1'b1, 3'd4);
    wait_valid(lat);
    exp_r = exp_q.pop_front();
    checks++;
    if (obs !== exp_r) begin failures++; $display("FAIL overflow_clear got %h required %h", obs, exp_r); end
    take_result();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    res_t hold;
    send_op(14'd1234, 14'd56, 1'b0, 3'd6);
    wait_valid(lat);
    hold = obs;
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'($urandom);
      i_error = DW'($urandom);
      i_reference = DW'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (obs !== hold || o_ready !== 1'b0 || o_valid !== 1'b1) bad++;
    end
    i_valid = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL backpressure_hold unstable_cycles=%0d required 0", bad); end
    exp_r = exp_q.pop_front();
    checks++;
    if (obs !== exp_r) begin failures++; $display("FAIL backpressure_result got %h required %h", obs, exp_r); end
    take_result();
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release o_ready=%b o_valid=%b required 1/0", o_ready, o_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL ignored_pulses o_valid=%b required 0", o_valid); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int exp_lat;
    logic [DW-1:0] e, r;
    logic s;
    for (int ch = 0; ch < 8; ch++) begin
      e = DW'($urandom);
      r = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
      s = 1'($urandom);
      exp_lat = (r == '0) ? 0 : LAT;
      send_op(e, r, s, CW'(ch));
      wait_valid(lat);
      exp_r = exp_q.pop_front();
      checks++;
      if (lat != exp_lat || obs !== exp_r) begin
        failures++;
        $display("FAIL back_to_back ch=%0d lat=%0d/%0d got %h required %h", ch, lat, exp_lat, obs, exp_r);
      end
      take_result();
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    send_op(14'd3000, 14'd13, 1'b0, 3'd7);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    checks++;
    if ({obs, o_valid, o_ready} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got %h required 0", {obs, o_valid, o_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_release o_ready=%b o_valid=%b required 1/0", o_ready, o_valid);
    end
    send_op(14'h3A50, 14'd13, 1'b1, 3'd7);
    wait_valid(lat);
    exp_r = exp_q.pop_front();
    checks++;
    if (lat != LAT || obs !== exp_r) begin
      failures++;
      $display("FAIL reset_mid_recover lat=%0d got %h required %h", lat, obs, exp_r);
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover size=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multichannel_ratio_divider.md
Name: multichannel_ratio_divider

Overview:
- Parametrised sequential fixed-point divider; successor of the current error/reference processor.
- Computes error/reference as a signed or unsigned fixed-point ratio with FRAC_BITS fractional quotient bits.
- Each operation carries a channel tag, so several control loops can share one divider.
- Uses a ready/valid handshake on both sides and flags divide-by-zero and signed overflow; sits between the error/reference front end and the loop controller.

Parameters:
DATA_SIZE, 14, width of i_error, i_reference and o_remainder
FRAC_BITS, 8, fractional bits appended to the quotient
CHANNEL_SIZE, 3, width of the channel tag (up to 2^CHANNEL_SIZE channels)
RESULT_SIZE (localparam), DATA_SIZE+FRAC_BITS, quotient width

Ports:
i_clock  input  1  system clock, rising edge
i_reset  input  1  asynchronous, active-low reset
i_valid  input  1  operands valid
o_ready  output  1  divider can accept operands
i_error  input  DATA_SIZE  dividend
i_reference  input  DATA_SIZE  divisor
i_signed  input  1  1 = two's-complement operands, 0 = unsigned
i_channel  input  CHANNEL_SIZE  tag travelling with the operation
o_valid  output  1  result valid
i_ready  input  1  downstream accepts the result
o_quotient  output  RESULT_SIZE  (error<<FRAC_BITS)/reference, truncated toward zero
o_remainder  output  DATA_SIZE  remainder; same sign as the dividend
o_channel  output  CHANNEL_SIZE  tag of the result
o_div_by_zero  output  1  reference was 0
o_overflow  output  1  signed result saturated

Behaviour:
Reset and transfers:
- While i_reset=0, the FSM goes to IDLE.
- During reset, o_valid=0, o_ready=0, and every data and flag output is 0.
- o_ready rises on the first clock edge after reset release.
- Reset asserted mid-operation aborts the operation; no result is produced.
- Accept occurs on an edge where i_valid=1 and o_ready=1. Operands, mode and channel are latched there, and later input changes are ignored.
- o_ready=1 only in IDLE, so there is one operation in flight.

FSM states: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on accept with reference!=0. Latch |error|<<FRAC_BITS and |reference|; sign handling only when i_signed=1. Clear the partial remainder and the iteration counter.
- IDLE -> DONE directly on accept with reference==0. o_valid is then high after exactly 1 edge.
  - o_div_by_zero=1 and o_remainder=error.
  - Unsigned: o_quotient is all ones.
  - Signed: o_quotient = max positive (0 followed by ones) if error>=0, otherwise min negative (1 followed by zeros).
- CALC: radix-2 restoring division, one quotient bit per edge (MSB first), for RESULT_SIZE edges, counter 0..RESULT_SIZE-1. Last count -> FIX.
- FIX: apply the sign. Quotient is negative iff signed and the operand signs differ. Remainder takes the dividend's sign. Outputs are registered and o_valid=1 from this edge -> DONE.
- Latency for a nonzero divisor: o_valid is high RESULT_SIZE+1 edges after the accept edge (23 with defaults).
- DONE: outputs hold stable while i_ready=0 (backpressure can last indefinitely). On an edge with i_ready=1, o_valid drops -> IDLE, and o_ready rises on that same edge. There is no same-cycle accept from DONE.

Overflow:
- Occurs iff signed, error = min negative and reference = -1.
- o_quotient = max positive, o_remainder=0, o_overflow=1.
- Unsigned results never overflow, because RESULT_SIZE covers the full range.

Invariants and flag clearing:
- |remainder| < |reference| for reference != 0.
- Flags are cleared on every accept.

Test Plan:
1. Unsigned, error=100, reference=7, channel=5 -> after 23 edges: o_quotient=3657, o_remainder=1, o_channel=5, flags 0.
2. Signed, error=-100, reference=7 -> o_quotient=-3657 (0x3FF1B7), o_remainder=-1 (0x3FFF); signed -100/-7 -> 3657, remainder -1.
3. Unsigned 5/0 -> o_valid 1 edge after accept, o_quotient=0x3FFFFF, o_remainder=5, o_div_by_zero=1; signed -5/0 -> o_quotient=0x200000.
4. Signed error=0x2000 (-8192), reference=0x3FFF (-1) -> o_quotient=0x1FFFFF, o_remainder=0, o_overflow=1.
5. Hold i_ready=0 for 10 cycles after o_valid -> outputs stable and o_ready=0; i_valid pulses during this time are ignored. Raise i_ready -> o_ready=1 on the next edge, then back-to-back ops on channels 0..7 return correct tags in order.
6. Assert i_reset low 10 edges into CALC -> all outputs 0 immediately. Release -> o_ready=1 after one edge, o_valid stays 0 until a new operation completes correctly.
